// File: rtl/batrider_colmix.sv
// rtl/batrider_colmix.sv - text/GP9001 pixel select, palette lookup, xBGR555 to RGB888 expansion.
// Optional build macro: BATRIDER_COLMIX_LAYER_MASK_EN adds the LAYER_EN per-layer enable port.
module batrider_colmix #(
  parameter int RAM_LAT = 2
) (
  input  logic        CLK96,
  input  logic        RESET96,
  input  logic        PIXEL_CEN,
  input  logic        HB,
  input  logic        VB,
  input  logic [10:0] EXTRATEXT_PIXEL,
  input  logic [10:0] GP_PIXEL,
`ifdef BATRIDER_COLMIX_LAYER_MASK_EN
  input  logic [1:0]  LAYER_EN,
`endif
  output logic [10:0] PALRAM_ADDR,
  input  logic [15:0] PALRAM_DATA,
  output logic [7:0]  RED,
  output logic [7:0]  GREEN,
  output logic [7:0]  BLUE,
  output logic        HB_OUT,
  output logic        VB_OUT,
  output logic        OVERRUN
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] cap_q, cap_d;
  logic        hbc_q, hbc_d, vbc_q, vbc_d;
  logic [10:0] addr_q, addr_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic        hbo_q, hbo_d, vbo_q, vbo_d;

  logic [1:0]  layer_en;
  logic        text_op, gp_op, blank, abort;
  logic [10:0] sel_idx;
  logic [15:0] src;

`ifdef BATRIDER_COLMIX_LAYER_MASK_EN
  assign layer_en = LAYER_EN;
`else
  assign layer_en = 2'b11;
`endif

  assign text_op = (|EXTRATEXT_PIXEL[3:0]) & layer_en[1];
  assign gp_op   = (|GP_PIXEL[3:0]) & layer_en[0];
  assign sel_idx = text_op ? EXTRATEXT_PIXEL : (gp_op ? GP_PIXEL : 11'd0);
  assign blank   = HB | VB;
  assign abort   = PIXEL_CEN & ((state_q == S_ISSUE) | (state_q == S_WAIT));
  // An aborted lookup never completed, so the pixel it belonged to shows black.
  assign src     = abort ? 16'd0 : cap_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    hbc_d   = hbc_q;
    vbc_d   = vbc_q;
    addr_d  = addr_q;
    ovr_d   = ovr_q | abort;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    hbo_d   = hbo_q;
    vbo_d   = vbo_q;
    case (state_q)
      S_ISSUE: begin
        cnt_d   = 2'(RAM_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          cap_d   = PALRAM_DATA;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // DONE accepts a strobe too: at minimum spacing it lands on the DONE cycle.
    if (PIXEL_CEN) begin
      red_d   = {src[4:0], src[4:2]};
      green_d = {src[9:5], src[9:7]};
      blue_d  = {src[14:10], src[14:12]};
      hbo_d   = hbc_q;
      vbo_d   = vbc_q;
      hbc_d   = HB;
      vbc_d   = VB;
      cap_d   = 16'd0;
      if (blank) begin
        state_d = S_DONE;
      end else begin
        state_d = S_ISSUE;
        addr_d  = sel_idx;
      end
    end
  end

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      cap_q   <= 16'd0;
      hbc_q   <= 1'b0;
      vbc_q   <= 1'b0;
      addr_q  <= 11'd0;
      ovr_q   <= 1'b0;
      red_q   <= 8'd0;
      green_q <= 8'd0;
      blue_q  <= 8'd0;
      hbo_q   <= 1'b0;
      vbo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      hbc_q   <= hbc_d;
      vbc_q   <= vbc_d;
      addr_q  <= addr_d;
      ovr_q   <= ovr_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hbo_q   <= hbo_d;
      vbo_q   <= vbo_d;
    end
  end

  assign PALRAM_ADDR = addr_q;
  assign RED         = red_q;
  assign GREEN       = green_q;
  assign BLUE        = blue_q;
  assign HB_OUT      = hbo_q;
  assign VB_OUT      = vbo_q;
  assign OVERRUN     = ovr_q;

endmodule

// File: tb/tb_batrider_colmix.sv
// tb/tb_batrider_colmix.sv - pixel-level reference model bench for batrider_colmix.
// Honours BATRIDER_COLMIX_LAYER_MASK_EN when the design is built with it.
module tb_batrider_colmix;

  logic        CLK96 = 1'b0;
  logic        RESET96 = 1'b1;
  logic        PIXEL_CEN = 1'b0;
  logic        HB = 1'b0;
  logic        VB = 1'b0;
  logic [10:0] EXTRATEXT_PIXEL = 11'd0;
  logic [10:0] GP_PIXEL = 11'd0;
  logic [10:0] PALRAM_ADDR;
  logic [15:0] PALRAM_DATA;
  logic [7:0]  RED, GREEN, BLUE;
  logic        HB_OUT, VB_OUT, OVERRUN;
`ifdef BATRIDER_COLMIX_LAYER_MASK_EN
  logic [1:0]  LAYER_EN = 2'b11;
`endif

  batrider_colmix #(.RAM_LAT(2)) dut (
    .CLK96(CLK96),
    .RESET96(RESET96),
    .PIXEL_CEN(PIXEL_CEN),
    .HB(HB),
    .VB(VB),
    .EXTRATEXT_PIXEL(EXTRATEXT_PIXEL),
    .GP_PIXEL(GP_PIXEL),
`ifdef BATRIDER_COLMIX_LAYER_MASK_EN
    .LAYER_EN(LAYER_EN),
`endif
    .PALRAM_ADDR(PALRAM_ADDR),
    .PALRAM_DATA(PALRAM_DATA),
    .RED(RED),
    .GREEN(GREEN),
    .BLUE(BLUE),
    .HB_OUT(HB_OUT),
    .VB_OUT(VB_OUT),
    .OVERRUN(OVERRUN)
  );

  always #5 CLK96 = ~CLK96;

  // Palette RAM with two-cycle latency: address registered, then data registered.
  logic [15:0] pal [0:2047];
  logic [10:0] ram_a;
  always @(posedge CLK96) begin
    ram_a       <= PALRAM_ADDR;
    PALRAM_DATA <= pal[ram_a];
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_r = 8'd0, exp_g = 8'd0, exp_b = 8'd0;
  logic        exp_hb = 1'b0, exp_vb = 1'b0, exp_ovr = 1'b0;
  logic [10:0] exp_addr = 11'd0;
  bit          cmp_en = 1'b0;

  bit          have_prev = 1'b0;
  bit          prev_blank = 1'b0;
  logic [10:0] prev_idx = 11'd0;
  logic        prev_hb = 1'b0, prev_vb = 1'b0;
  int          since = 100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge CLK96) begin
    if (cmp_en) begin
      chk("red", {24'd0, RED}, {24'd0, exp_r});
      chk("green", {24'd0, GREEN}, {24'd0, exp_g});
      chk("blue", {24'd0, BLUE}, {24'd0, exp_b});
      chk("hb_out", {31'd0, HB_OUT}, {31'd0, exp_hb});
      chk("vb_out", {31'd0, VB_OUT}, {31'd0, exp_vb});
      chk("overrun", {31'd0, OVERRUN}, {31'd0, exp_ovr});
      chk("palram_addr", {21'd0, PALRAM_ADDR}, {21'd0, exp_addr});
    end
  end

  function automatic logic [10:0] model_sel(input logic [10:0] t, input logic [10:0] g,
                                            input logic [1:0] en);
    if ((t % 16) != 0 && en[1]) return t;
    if ((g % 16) != 0 && en[0]) return g;
    return 11'd0;
  endfunction

  function automatic logic [7:0] x5(input int c);
    return 8'(c * 8 + c / 4);
  endfunction

  task automatic step();
    @(posedge CLK96);
    #1;
  endtask

  task automatic model_reset();
    exp_r = 0; exp_g = 0; exp_b = 0;
    exp_hb = 0; exp_vb = 0; exp_ovr = 0; exp_addr = 0;
    have_prev = 0;
  endtask

  task automatic pixel(input logic [10:0] t, input logic [10:0] g, input logic h,
                       input logic v, input int spacing);
    logic [1:0]  en;
    logic [10:0] idx;
    logic [15:0] e;
    en = 2'b11;
`ifdef BATRIDER_COLMIX_LAYER_MASK_EN
    en = LAYER_EN;
`endif
    idx = model_sel(t, g, en);
    EXTRATEXT_PIXEL = t;
    GP_PIXEL = g;
    HB = h;
    VB = v;
    PIXEL_CEN = 1'b1;
    step();
    PIXEL_CEN = 1'b0;
    if (!have_prev) begin
      exp_r = 0; exp_g = 0; exp_b = 0; exp_hb = 0; exp_vb = 0;
    end else if (prev_blank || since < 4) begin
      exp_r = 0; exp_g = 0; exp_b = 0;
      exp_hb = prev_hb; exp_vb = prev_vb;
      if (!prev_blank) exp_ovr = 1'b1;
    end else begin
      e = pal[prev_idx];
      exp_r = x5(int'(e) % 32);
      exp_g = x5((int'(e) / 32) % 32);
      exp_b = x5((int'(e) / 1024) % 32);
      exp_hb = prev_hb; exp_vb = prev_vb;
    end
    if (!(h | v)) exp_addr = idx;
    have_prev = 1;
    prev_blank = h | v;
    prev_idx = idx;
    prev_hb = h;
    prev_vb = v;
    since = spacing;
    repeat (spacing - 1) step();
  endtask

  initial begin
    logic [10:0] t, g;
    logic        h, v;
    int          sp;
    for (int i = 0; i < 2048; i++) pal[i] = 16'($urandom);
    pal[11'h405] = 16'h7FFF;
    pal[11'h123] = 16'h001F;
    pal[11'h000] = 16'h03E0;
    model_reset();
    repeat (4) step();
    chk("rst_red", {24'd0, RED}, 32'd0);
    chk("rst_addr", {21'd0, PALRAM_ADDR}, 32'd0);
    chk("rst_overrun", {31'd0, OVERRUN}, 32'd0);
    RESET96 = 1'b0;
    step();
    cmp_en = 1'b1;

    pixel(11'h405, 11'h123, 0, 0, 4);
    chk("tw_addr", {21'd0, PALRAM_ADDR}, 32'h405);
    pixel(11'h400, 11'h123, 0, 0, 4);
    chk("tw_rgb", {8'd0, RED, GREEN, BLUE}, 32'hFFFFFF);
    chk("tt_addr", {21'd0, PALRAM_ADDR}, 32'h123);
    pixel(11'h000, 11'h010, 0, 0, 4);
    chk("tt_rgb", {8'd0, RED, GREEN, BLUE}, 32'hFF0000);
    pixel(11'h405, 11'h123, 1, 0, 4);
    chk("bd_rgb", {8'd0, RED, GREEN, BLUE}, 32'h00FF00);
    chk("blank_addr", {21'd0, PALRAM_ADDR}, 32'h000);
    pixel(11'h405, 11'h123, 0, 0, 2);
    chk("blank_rgb", {8'd0, RED, GREEN, BLUE}, 32'h000000);
    chk("blank_hb", {31'd0, HB_OUT}, 32'd1);
    pixel(11'h400, 11'h123, 0, 0, 4);
    chk("ovr_flag", {31'd0, OVERRUN}, 32'd1);
    chk("ovr_black", {8'd0, RED, GREEN, BLUE}, 32'h000000);
    pixel(11'h405, 11'h000, 0, 0, 4);
    chk("ovr_next_rgb", {8'd0, RED, GREEN, BLUE}, 32'hFF0000);
    chk("ovr_sticky", {31'd0, OVERRUN}, 32'd1);

    pixel(11'h405, 11'h123, 0, 0, 3);
    RESET96 = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_rgb", {8'd0, RED, GREEN, BLUE}, 32'd0);
    chk("rst_mid_ovr", {31'd0, OVERRUN}, 32'd0);
    chk("rst_mid_addr", {21'd0, PALRAM_ADDR}, 32'd0);
    step();
    step();
    RESET96 = 1'b0;
    step();
    pixel(11'h405, 11'h123, 0, 0, 4);
    chk("post_rst_first", {8'd0, RED, GREEN, BLUE}, 32'd0);
    pixel(11'h000, 11'h000, 0, 0, 4);
    chk("post_rst_rgb", {8'd0, RED, GREEN, BLUE}, 32'hFFFFFF);

`ifdef BATRIDER_COLMIX_LAYER_MASK_EN
    LAYER_EN = 2'b01;
    pixel(11'h405, 11'h123, 0, 0, 4);
    chk("mask01_addr", {21'd0, PALRAM_ADDR}, 32'h123);
    LAYER_EN = 2'b00;
    pixel(11'h405, 11'h123, 0, 0, 4);
    chk("mask00_addr", {21'd0, PALRAM_ADDR}, 32'h000);
    LAYER_EN = 2'b11;
`endif

    for (int n = 0; n < 400; n++) begin
      t = 11'($urandom_range(0, 2047));
      g = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 2) == 0) t[3:0] = 4'd0;
      if ($urandom_range(0, 2) == 0) g[3:0] = 4'd0;
      h = ($urandom_range(0, 9) == 0);
      v = ($urandom_range(0, 14) == 0);
      sp = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(4, 7));
`ifdef BATRIDER_COLMIX_LAYER_MASK_EN
      LAYER_EN = 2'($urandom_range(0, 3));
`endif
      pixel(t, g, h, v, sp);
    end
    pixel(11'h000, 11'h000, 0, 0, 4);
    step();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/batrider_colmix.md
# batrider_colmix

Final colour stage of the Batrider video path. Once per pixel it picks between the extra-text layer pixel and the GP9001 composite pixel, then fetches the winning entry from palette RAM. It expands the xBGR555 entry to RGB888 and presents it, with delayed blanking, to the video output. It sits directly downstream of the extra-text line renderer and the GP9001 renderer, and upstream of the frame/scan output.

## Interface

Parameters:
- `RAM_LAT`, default 2: palette RAM read latency in CLK96 cycles (address registered to data valid). Legal values are 1–2.

Ports:
- `CLK96`  in  1  video/system clock.
- `RESET96`  in  1  reset, asynchronous, active-high. Clock is CLK96.
- `PIXEL_CEN`  in  1  pixel strobe, one CLK96 cycle wide. Minimum spacing is 4 cycles.
- `HB`  in  1  horizontal blank.
- `VB`  in  1  vertical blank.
- `EXTRATEXT_PIXEL`  in  11  text palette index. Transparent when `[3:0]==0`.
- `GP_PIXEL`  in  11  GP9001 palette index. Transparent when `[3:0]==0`.
- `PALRAM_ADDR`  out  11  palette RAM read address.
- `PALRAM_DATA`  in  16  palette RAM read data, xBGR555.
- `RED`  out  8  red output.
- `GREEN`  out  8  green output.
- `BLUE`  out  8  blue output.
- `HB_OUT`  out  1  `HB` delayed to match RGB.
- `VB_OUT`  out  1  `VB` delayed to match RGB.
- `OVERRUN`  out  1  sticky error flag; cleared only by reset.
- `LAYER_EN`  in  2  present only with `BATRIDER_COLMIX_LAYER_MASK_EN`. Bit 0 enables GP, bit 1 enables text.

## Operation

- **Reset values:** all outputs are 0 (`RED`/`GREEN`/`BLUE`, `PALRAM_ADDR`, `HB_OUT`, `VB_OUT`, `OVERRUN`). FSM is in IDLE and the capture register is 0.

- **Selection** happens on the `PIXEL_CEN` cycle, using sampled inputs:
  - Text index if the text pixel is opaque.
  - Otherwise the GP index if the GP pixel is opaque.
  - Otherwise backdrop index 0.
  - Text always wins when opaque. There is no priority field.

- **Blanking:**
  - If `HB|VB` is sampled high, the stage issues no RAM read and captures black (0).
  - `HB`/`VB` are still pipelined.

- **FSM states:**
  - IDLE: on `PIXEL_CEN`, go to ISSUE, or to DONE when blanked. Capture the selected index and blank flags.
  - ISSUE: drive `PALRAM_ADDR` with the index. Load the wait counter with `RAM_LAT-1`. Go to WAIT.
  - WAIT: decrement the counter. At 0, register `PALRAM_DATA` into the capture register and go to DONE.
  - DONE: hold. Return to IDLE.

- **Expansion** of the 16-bit entry:
  - Bits are `[14:10]` B, `[9:5]` G, `[4:0]` R. Bit 15 is ignored.
  - Each 5-bit channel `c` expands to `{c, c[4:2]}`. So `5'h1F → 8'hFF` and `5'h00 → 8'h00`.

- **Output update:** on each `PIXEL_CEN`, `RED`/`GREEN`/`BLUE`/`HB_OUT`/`VB_OUT` load from the capture register of the previous pixel.

- **Overrun:** if `PIXEL_CEN` arrives while the FSM is in ISSUE or WAIT:
  - Abort the in-flight lookup.
  - Capture black for that pixel.
  - Set `OVERRUN`.
  - Restart on the new pixel (go to ISSUE with the new index).

- **Reset mid-lookup:** everything returns to reset values immediately. The first valid RGB appears one pixel after the first post-reset `PIXEL_CEN`.

## Timing

- Let cycle 0 be the `PIXEL_CEN` cycle. `PALRAM_ADDR` is valid at cycle 1.
- With `RAM_LAT=2`, data is captured at the end of cycle 3. DONE is reached at cycle 4; at the 4-cycle minimum spacing it coincides with the next `PIXEL_CEN`, which is not an overrun.
- Pixel latency is exactly one `PIXEL_CEN` period, input sample to RGB output. `HB_OUT`/`VB_OUT` have identical latency.
- Outputs change only on `PIXEL_CEN` cycles. They hold between strobes.
- `PALRAM_ADDR` holds its last value in IDLE/DONE. It is not cleared per pixel.

## Configuration

- `BATRIDER_COLMIX_LAYER_MASK_EN` defined:
  - The `LAYER_EN` port exists.
  - A layer whose enable bit is 0 is treated as transparent before selection.
- Undefined:
  - The port is absent.
  - Both layers are always enabled.
  - Selection logic is identical to `LAYER_EN=2'b11`.

## Test plan

- **Text wins:** text=`11'h405`, GP=`11'h123`, PAL[`0x405`]=`16'h7FFF` → next pixel RGB=`FF,FF,FF`, `PALRAM_ADDR`=`0x405` at cycle 1.
- **Text transparent:** text=`11'h400`, GP=`11'h123`, PAL[`0x123`]=`16'h001F` → RGB=`FF,00,00`. Both transparent with PAL[0]=`16'h03E0` → RGB=`00,FF,00`.
- **Blanking:** `HB=1` with opaque inputs → no address change, RGB=0, `HB_OUT=1` one pixel later.
- **Overrun:** `PIXEL_CEN` spacing 2 cycles → `OVERRUN=1` and stays set. The affected pixel is black; the following pixel, at 4-cycle spacing, is correct.
- **Reset:** `RESET96` asserted during WAIT → all outputs 0 within the same cycle. After release, the first `PIXEL_CEN` gives correct RGB one pixel later.
- **Layer mask (macro defined):** `LAYER_EN=2'b01`, text=`11'h405`, GP=`11'h123` → address `0x123`. `LAYER_EN=2'b00` → address 0.
